// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: drives an external 1-bit ALU slice LSB first,
// assembles the WIDTH-bit result and derives carry/overflow/zero/err flags.
module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUOp,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic [3:0]       alu_op,
  input  logic             alu_result,
  input  logic             alu_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             err
);

  localparam int IDXW = $clog2(WIDTH);
  localparam logic [IDXW-1:0] LAST = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [3:0]       op_reg;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic [WIDTH-1:0] res_next;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

  function automatic logic op_arith(input logic [3:0] op);
    return (op == 4'b0010) || (op == 4'b0110);
  endfunction

  // Slice drives are pure decodes of registered state, so the slice sees
  // stable inputs for the whole cycle and the edge captures its outputs.
  assign alu_a   = (state == RUN) & a_reg[idx];
  assign alu_b   = (state == RUN) & b_reg[idx];
  assign alu_cin = (state == RUN) & carry;
  assign alu_op  = op_reg;

  always_comb begin
    res_next      = result;
    res_next[idx] = alu_result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      result    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            if (op_legal(ALUOp)) begin
              a_reg  <= a;
              b_reg  <= b;
              op_reg <= ALUOp;
              idx    <= '0;
              carry  <= ALUOp[2];
              err    <= 1'b0;
              busy   <= 1'b1;
              state  <= RUN;
            end else begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        RUN: begin
          result <= res_next;
          carry  <= alu_cout;
          idx    <= idx + 1'b1;
          if (idx == LAST) begin
            // carry still holds the carry into the MSB at this edge
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            zero  <= (res_next == '0);
            state <= DONE;
            if (op_arith(op_reg)) begin
              carry_out <= alu_cout;
              overflow  <= carry ^ alu_cout;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_alu_ctrl.md
SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (all state updates on the rising edge) and reset.
REQ-002 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 Ports: a, b  input  WIDTH  operands, captured when start is accepted.
REQ-007 Port: ALUOp  input  4  operation code, captured when start is accepted.
REQ-008 Ports: alu_a, alu_b, alu_cin  output  1  per-bit drive to the external ALU_1_bit a/b/CarryIn.
REQ-009 Port: alu_op  output  4  drive to ALU_1_bit ALUOp.
REQ-010 Ports: alu_result, alu_cout  input  1  ALU_1_bit Result/CarryOut, combinational from the alu_* drives.
REQ-011 Port: busy  output  1  high in RUN.
REQ-012 Port: done  output  1  one-cycle completion pulse.
REQ-013 Port: result  output  WIDTH  assembled result.
REQ-014 Ports: carry_out, overflow, zero, err  output  1  status flags.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE.
REQ-016 Legal ALUOp: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR; all other codes are illegal.
REQ-017 IDLE, start=1, legal op: latch a, b, ALUOp; bit index := 0; carry := ALUOp[2]; clear result/flags; next state RUN.
REQ-018 IDLE, start=1, illegal op: err := 1; result := 0; all other flags := 0; next state DONE; no RUN cycles.
REQ-019 RUN, bit index i: alu_a = a_reg[i], alu_b = b_reg[i], alu_cin = carry, alu_op = latched ALUOp, all combinational from registers.
REQ-020 Each RUN edge: result[i] := alu_result; carry := alu_cout; i := i+1. On i = WIDTH-1, next state is DONE.
REQ-021 RUN SHALL last exactly WIDTH cycles, LSB first; ALU_1_bit has zero latency.
REQ-022 At the final bit, carry into MSB SHALL be saved. overflow := carry_in_msb XOR alu_cout for ADD/SUB, 0 otherwise.
REQ-023 carry_out SHALL be the final alu_cout for ADD/SUB, 0 for logic ops.
REQ-024 zero SHALL be 1 in DONE iff result == 0 and err == 0.
REQ-025 DONE SHALL last one cycle with done = 1, then return to IDLE.
REQ-026 Latency: start accepted at edge N, done is high in cycle N+WIDTH+1 for legal ops and in cycle N+1 for illegal ops.
REQ-027 start in RUN or DONE SHALL be ignored (no queuing). start in the cycle after DONE is accepted.
REQ-028 result and the status flags SHALL hold their values from DONE until the next accepted start.
REQ-029 Outside RUN: alu_a, alu_b, alu_cin = 0 and alu_op = latched ALUOp.
REQ-030 Changes on a, b, ALUOp during RUN SHALL NOT affect the operation in progress.

Reset
REQ-031 reset=1 at an edge SHALL force IDLE, index 0, carry 0, latched operands and ALUOp 0, and result, busy, done, carry_out, overflow, zero, err to 0.
REQ-032 reset SHALL take priority over start and over any in-flight operation.
REQ-033 reset mid-RUN SHALL abandon the operation with no done pulse.

Verification (WIDTH=8, bench instantiates ALU_1_bit)
REQ-034 ADD 0x7F+0x01, start at edge N -> done in cycle N+9, result 0x80, carry_out 0, overflow 1, zero 0, busy high for 8 cycles.
REQ-035 SUB 0x05-0x05 -> result 0x00, zero 1, carry_out 1, overflow 0. SUB 0x03-0x05 -> result 0xFE, carry_out 0.
REQ-036 Logic ops with a=0xF0, b=0x3C: AND -> 0x30, OR -> 0xFC. NOR 0x0F,0xF0 -> 0x00 with zero 1. carry_out and overflow are 0 in all three cases.
REQ-037 start re-asserted every cycle during RUN -> single done pulse and the first operation's result. Back-to-back start the cycle after DONE -> accepted.
REQ-038 reset asserted on the 3rd RUN cycle -> next cycle busy 0, done 0, result 0x00. A following ADD 0x01+0x01 completes with result 0x02.
REQ-039 ALUOp 0111 -> done one cycle after start, err 1, result 0x00, zero 0, busy never high.
